fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO that generalises the team's 8-bit synchronous FIFO. It adds configurable data width and depth, programmable almost-full and almost-empty thresholds, and an occupancy count output. It also adds sticky overflow/underflow error flags, and selects at elaboration time between standard-read and first-word-fall-through (FWFT) modes. It sits between UART/SPI/ADC front-ends and their consumers, and stores data in an inferred dual-port RAM with a registered read port.

---
 rtl/fifo_sync_param.sv | 126 ++++++++++++
 tb/tb_fifo_sync_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with FWFT option and sticky error flags
// Dual-port RAM with registered read port; in FWFT mode the read register doubles as the head word.
module fifo_sync_param #(
  parameter int pDataWidth   = 8,
  parameter int pFifoDepth   = 8,
  parameter int pAlmostFull  = pFifoDepth - 2,
  parameter int pAlmostEmpty = 2,
  parameter int pFwft        = 0
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iWrEn,
  input  logic [pDataWidth-1:0]             iWrData,
  output logic                              oWrFull,
  output logic                              oAlmostFull,
  input  logic                              iRdEn,
  output logic [pDataWidth-1:0]             oRdData,
  output logic                              oRdValid,
  output logic                              oRdEmpty,
  output logic                              oAlmostEmpty,
  output logic [$clog2(pFifoDepth+1)-1:0]   oCount,
  input  logic                              iClrErr,
  output logic                              oOverflow,
  output logic                              oUnderflow
);

  localparam int cAddrW  = $clog2(pFifoDepth);
  localparam int cCountW = $clog2(pFifoDepth + 1);

  localparam logic [cAddrW-1:0]  cLastAddr    = cAddrW'(pFifoDepth - 1);
  localparam logic [cAddrW-1:0]  cAddrOne     = cAddrW'(1);
  localparam logic [cCountW-1:0] cCountOne    = cCountW'(1);
  localparam logic [cCountW-1:0] cDepth       = cCountW'(pFifoDepth);
  localparam logic [cCountW-1:0] cAlmostFull  = cCountW'(pAlmostFull);
  localparam logic [cCountW-1:0] cAlmostEmpty = cCountW'(pAlmostEmpty);

  logic [pDataWidth-1:0] mem [pFifoDepth];
  logic [cAddrW-1:0]     wrPtr;
  logic [cAddrW-1:0]     rdPtr;
  logic [cCountW-1:0]    count;
  logic [pDataWidth-1:0] rdDataQ;
  logic                  validQ;
  logic                  overflowQ;
  logic                  underflowQ;

  logic wFull;
  logic wEmpty;
  logic wRdAccept;
  logic wWrAccept;
  logic wRamHasData;
  logic wRamRd;

  function automatic logic [cAddrW-1:0] nextPtr(input logic [cAddrW-1:0] ptr);
    return (ptr == cLastAddr) ? '0 : ptr + cAddrOne;
  endfunction

  assign wFull       = (count == cDepth);
  assign wEmpty      = (pFwft != 0) ? !validQ : (count == '0);
  assign wRdAccept   = iRdEn && !wEmpty;
  assign wWrAccept   = iWrEn && (!wFull || wRdAccept);
  // In FWFT mode count includes the head register, so the RAM holds count - validQ words.
  assign wRamHasData = (count > {{(cCountW-1){1'b0}}, validQ});
  assign wRamRd      = (pFwft != 0) ? (wRamHasData && (!validQ || wRdAccept)) : wRdAccept;

  always_ff @(posedge iClk) begin
    if (wWrAccept) begin
      mem[wrPtr] <= iWrData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      rdDataQ    <= '0;
      validQ     <= 1'b0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (wWrAccept) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (wRamRd) begin
        rdPtr   <= nextPtr(rdPtr);
        rdDataQ <= mem[rdPtr];
      end
      case ({wWrAccept, wRdAccept})
        2'b10:   count <= count + cCountOne;
        2'b01:   count <= count - cCountOne;
        default: count <= count;
      endcase
      if (pFwft != 0) begin
        if (wRamRd) begin
          validQ <= 1'b1;
        end else if (wRdAccept) begin
          validQ <= 1'b0;
        end
      end else begin
        validQ <= wRdAccept;
      end
      // Setting an error flag takes priority over a simultaneous clear.
      if (iWrEn && !wWrAccept) begin
        overflowQ <= 1'b1;
      end else if (iClrErr) begin
        overflowQ <= 1'b0;
      end
      if (iRdEn && wEmpty) begin
        underflowQ <= 1'b1;
      end else if (iClrErr) begin
        underflowQ <= 1'b0;
      end
    end
  end

  assign oWrFull      = wFull;
  assign oAlmostFull  = (count >= cAlmostFull);
  assign oRdEmpty     = wEmpty;
  assign oAlmostEmpty = (count <= cAlmostEmpty);
  assign oCount       = count;
  assign oRdData      = rdDataQ;
  assign oRdValid     = validQ;
  assign oOverflow    = overflowQ;
  assign oUnderflow   = underflowQ;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard bench for fifo_sync_param (std depth 8, std depth 5, FWFT depth 8)
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  logic       wrEnA = 0, rdEnA = 0, clrA = 0;
  logic [7:0] wrDataA = 0, dataA;
  logic       fullA, afA, validA, emptyA, aeA, ovfA, udfA;
  logic [3:0] countA;

  logic       wrEnB = 0, rdEnB = 0, clrB = 0;
  logic [7:0] wrDataB = 0, dataB;
  logic       fullB, afB, validB, emptyB, aeB, ovfB, udfB;
  logic [2:0] countB;

  logic       wrEnF = 0, rdEnF = 0, clrF = 0;
  logic [7:0] wrDataF = 0, dataF;
  logic       fullF, afF, validF, emptyF, aeF, ovfF, udfF;
  logic [3:0] countF;

  logic [7:0] expA[$];
  logic [7:0] expB[$];
  logic [7:0] expF[$];

  fifo_sync_param #(.pDataWidth(8), .pFifoDepth(8)) dutA (
    .iClk(clk), .iRst(rst), .iWrEn(wrEnA), .iWrData(wrDataA), .oWrFull(fullA),
    .oAlmostFull(afA), .iRdEn(rdEnA), .oRdData(dataA), .oRdValid(validA),
    .oRdEmpty(emptyA), .oAlmostEmpty(aeA), .oCount(countA), .iClrErr(clrA),
    .oOverflow(ovfA), .oUnderflow(udfA)
  );

  fifo_sync_param #(.pDataWidth(8), .pFifoDepth(5)) dutB (
    .iClk(clk), .iRst(rst), .iWrEn(wrEnB), .iWrData(wrDataB), .oWrFull(fullB),
    .oAlmostFull(afB), .iRdEn(rdEnB), .oRdData(dataB), .oRdValid(validB),
    .oRdEmpty(emptyB), .oAlmostEmpty(aeB), .oCount(countB), .iClrErr(clrB),
    .oOverflow(ovfB), .oUnderflow(udfB)
  );

  fifo_sync_param #(.pDataWidth(8), .pFifoDepth(8), .pFwft(1)) dutF (
    .iClk(clk), .iRst(rst), .iWrEn(wrEnF), .iWrData(wrDataF), .oWrFull(fullF),
    .oAlmostFull(afF), .iRdEn(rdEnF), .oRdData(dataF), .oRdValid(validF),
    .oRdEmpty(emptyF), .oAlmostEmpty(aeF), .oCount(countF), .iClrErr(clrF),
    .oOverflow(ovfF), .oUnderflow(udfF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (validA) begin
      if (expA.size() == 0) check("A spurious rdValid", validA, 0);
      else check("A rdData", dataA, expA.pop_front());
    end
    if (validB) begin
      if (expB.size() == 0) check("B spurious rdValid", validB, 0);
      else check("B rdData", dataB, expB.pop_front());
    end
    if (rdEnF && !emptyF) begin
      if (expF.size() == 0) check("F spurious head", emptyF, 1);
      else check("F head data", dataF, expF.pop_front());
    end
  end

  initial begin
    tick();
    tick();
    rst = 0;
    check("A reset rdEmpty", emptyA, 1);
    check("A reset almostEmpty", aeA, 1);
    check("A reset wrFull", fullA, 0);
    check("A reset almostFull", afA, 0);
    check("A reset count", countA, 0);
    check("A reset rdValid", validA, 0);
    check("A reset overflow", ovfA, 0);
    check("A reset underflow", udfA, 0);
    check("A reset rdData", dataA, 0);
    check("F reset rdEmpty", emptyF, 1);

    for (int i = 0; i < 8; i++) begin
      wrEnA = 1;
      wrDataA = 8'h10 + 8'(i);
      tick();
      if (i == 0) check("A empty after first write", emptyA, 0);
      check("A fill count", countA, i + 1);
      check("A fill almostFull", afA, (i + 1 >= 6) ? 1 : 0);
      check("A fill wrFull", fullA, (i + 1 == 8) ? 1 : 0);
    end
    wrDataA = 8'h99;
    tick();
    wrEnA = 0;
    check("A overflow on full write", ovfA, 1);
    check("A count after overflow", countA, 8);
    for (int i = 0; i < 8; i++) begin
      rdEnA = 1;
      expA.push_back(8'h10 + 8'(i));
      tick();
      check("A rdValid after rdEn", validA, 1);
    end
    rdEnA = 0;
    tick();
    check("A rdValid drops", validA, 0);
    check("A rdData holds", dataA, 8'h17);
    check("A empty after drain", emptyA, 1);
    check("A almostEmpty after drain", aeA, 1);
    check("A underflow untouched", udfA, 0);

    clrA = 1;
    tick();
    clrA = 0;
    check("A overflow cleared", ovfA, 0);
    for (int i = 0; i < 8; i++) begin
      wrEnA = 1;
      wrDataA = 8'h20 + 8'(i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      wrDataA = 8'h30 + 8'(i);
      rdEnA = 1;
      expA.push_back(8'h20 + 8'(i));
      tick();
      check("A count during full rd+wr", countA, 8);
      check("A no overflow on full rd+wr", ovfA, 0);
    end
    wrEnA = 0;
    for (int i = 3; i < 8; i++) begin
      expA.push_back(8'h20 + 8'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      expA.push_back(8'h30 + 8'(i));
      tick();
    end
    rdEnA = 0;
    tick();
    check("A empty after rd+wr drain", countA, 0);

    for (int i = 0; i < 5; i++) begin
      wrEnB = 1;
      wrDataB = 8'h60 + 8'(i);
      tick();
    end
    check("B wrFull at 5", fullB, 1);
    check("B count at 5", countB, 5);
    check("B almostFull at 5", afB, 1);
    for (int k = 0; k < 15; k++) begin
      wrDataB = 8'h65 + 8'(k);
      rdEnB = 1;
      expB.push_back(8'h60 + 8'(k));
      tick();
      check("B count during wrap", countB, 5);
    end
    wrEnB = 0;
    for (int k = 15; k < 20; k++) begin
      expB.push_back(8'h60 + 8'(k));
      tick();
    end
    rdEnB = 0;
    tick();
    check("B count after drain", countB, 0);
    check("B empty after drain", emptyB, 1);
    check("B no overflow", ovfB, 0);
    check("B no underflow", udfB, 0);

    wrEnF = 1;
    wrDataF = 8'hA5;
    tick();
    wrEnF = 0;
    check("F empty at N+1", emptyF, 1);
    check("F count at N+1", countF, 1);
    tick();
    check("F empty at N+2", emptyF, 0);
    check("F data at N+2", dataF, 8'hA5);
    check("F rdValid at N+2", validF, 1);
    rdEnF = 1;
    expF.push_back(8'hA5);
    tick();
    rdEnF = 0;
    check("F empty after pop", emptyF, 1);
    check("F count after pop", countF, 0);
    check("F no underflow yet", udfF, 0);
    rdEnF = 1;
    tick();
    rdEnF = 0;
    check("F underflow set", udfF, 1);
    check("F count after underflow", countF, 0);
    rdEnF = 1;
    clrF = 1;
    tick();
    rdEnF = 0;
    check("F set beats clear", udfF, 1);
    tick();
    clrF = 0;
    check("F underflow cleared", udfF, 0);
    for (int i = 0; i < 3; i++) begin
      wrEnF = 1;
      wrDataF = 8'hB0 + 8'(i);
      tick();
    end
    wrEnF = 0;
    tick();
    check("F count 3", countF, 3);
    check("F head B0", dataF, 8'hB0);
    for (int i = 0; i < 3; i++) begin
      rdEnF = 1;
      check("F no bubble", emptyF, 0);
      expF.push_back(8'hB0 + 8'(i));
      tick();
    end
    rdEnF = 0;
    check("F empty after burst", emptyF, 1);
    check("F count after burst", countF, 0);
    check("F no overflow", ovfF, 0);

    for (int i = 0; i < 4; i++) begin
      wrEnA = 1;
      wrDataA = 8'h40 + 8'(i);
      tick();
    end
    wrEnA = 0;
    check("A count before reset", countA, 4);
    rst = 1;
    tick();
    rst = 0;
    check("A mid reset count", countA, 0);
    check("A mid reset rdEmpty", emptyA, 1);
    check("A mid reset almostEmpty", aeA, 1);
    check("A mid reset wrFull", fullA, 0);
    check("A mid reset almostFull", afA, 0);
    check("A mid reset rdValid", validA, 0);
    check("A mid reset rdData", dataA, 0);
    check("A mid reset overflow", ovfA, 0);
    wrEnA = 1;
    wrDataA = 8'h55;
    tick();
    wrEnA = 0;
    rdEnA = 1;
    expA.push_back(8'h55);
    tick();
    rdEnA = 0;
    tick();
    tick();

    check("A scoreboard drained", expA.size(), 0);
    check("B scoreboard drained", expB.size(), 0);
    check("F scoreboard drained", expF.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
